// File: rtl/key_edge_pio_pkg.sv
// Shared constants for key_edge_pio: register map addresses and default
// parameter values.
package key_edge_pio_pkg;

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_RISE  = 3'd1;
  localparam logic [2:0] ADDR_MASK  = 3'd2;
  localparam logic [2:0] ADDR_CAPT  = 3'd3;
  localparam logic [2:0] ADDR_FALL  = 3'd4;
  localparam logic [2:0] ADDR_DBLIM = 3'd5;

  localparam int DEF_WIDTH    = 2;
  localparam int DEF_DB_W     = 16;
  localparam int DEF_DB_RESET = 50000;

endpackage

// File: rtl/key_debounce.sv
// One debounced key channel. With KEY_EDGE_PIO_DEBOUNCE_EN the output follows
// the synchronized input only after term_i+1 consecutive mismatching cycles;
// without it the output is the synchronized input registered once.
module key_debounce #(
  parameter int DB_W = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sync_i,
  input  logic [DB_W-1:0] term_i,
  input  logic            clr_i,
  output logic            q_o
);

  logic q_q;
  logic q_d;

`ifdef KEY_EDGE_PIO_DEBOUNCE_EN
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;

  // NOTE: every path assigns both next-state values up front, so no latch is inferred.
  always_comb begin
    cnt_d = '0;
    q_d   = q_q;
    if (clr_i || (sync_i == q_q)) begin
      cnt_d = '0;
    end else if (cnt_q == term_i) begin
      q_d   = sync_i;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments and a reset sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      q_q   <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end
`else
  logic unused_ctl;
  assign unused_ctl = ^{term_i, clr_i};
  assign q_d        = sync_i;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q <= 1'b1;
    end else begin
      q_q <= q_d;
    end
  end
`endif

  assign q_o = q_q;

endmodule

// File: rtl/key_edge_pio.sv
// Key input PIO: synchronizer, per-channel debounce, rise/fall edge capture
// with write-1-to-clear and masked IRQ. Debounce enabled by KEY_EDGE_PIO_DEBOUNCE_EN.
module key_edge_pio
  import key_edge_pio_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DB_W     = DEF_DB_W,
  parameter int DB_RESET = DEF_DB_RESET
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [DB_W-1:0] DB_INIT = DB_W'(DB_RESET);

  logic [WIDTH-1:0] s1_q, s2_q, qd_q, q;
  logic [WIDTH-1:0] rise_q, fall_q, mask_q, cap_q, cap_d, edges;
  logic [31:0]      rd_q, rd_d;
  logic [DB_W-1:0]  term;
  logic             db_clr;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^{writedata, DB_INIT};

`ifdef KEY_EDGE_PIO_DEBOUNCE_EN
  logic [DB_W-1:0] dblim_q;

  // A limit of zero behaves like one: the counter terminates at max(limit,1)-1.
  assign term   = (dblim_q == '0) ? '0 : dblim_q - 1'b1;
  assign db_clr = wr_en && (address == ADDR_DBLIM);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dblim_q <= DB_INIT;
    end else if (db_clr) begin
      dblim_q <= writedata[DB_W-1:0];
    end
  end
`else
  assign term   = '0;
  assign db_clr = 1'b0;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    key_debounce #(.DB_W(DB_W)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .sync_i  (s2_q[i]),
      .term_i  (term),
      .clr_i   (db_clr),
      .q_o     (q[i])
    );
  end

  assign edges = (q & ~qd_q & rise_q) | (~q & qd_q & fall_q);

  // A new edge wins over a simultaneous clear of the same bit.
  always_comb begin
    cap_d = cap_q;
    if (wr_en && (address == ADDR_CAPT)) begin
      cap_d = cap_q & ~writedata[WIDTH-1:0];
    end
    cap_d = cap_d | edges;
  end

  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA:  rd_d[WIDTH-1:0] = q;
      ADDR_RISE:  rd_d[WIDTH-1:0] = rise_q;
      ADDR_MASK:  rd_d[WIDTH-1:0] = mask_q;
      ADDR_CAPT:  rd_d[WIDTH-1:0] = cap_q;
      ADDR_FALL:  rd_d[WIDTH-1:0] = fall_q;
`ifdef KEY_EDGE_PIO_DEBOUNCE_EN
      ADDR_DBLIM: rd_d[DB_W-1:0]  = dblim_q;
`endif
      default:    rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q   <= '1;
      s2_q   <= '1;
      qd_q   <= '1;
      rise_q <= '0;
      fall_q <= '1;
      mask_q <= '0;
      cap_q  <= '0;
      rd_q   <= '0;
    end else begin
      s1_q  <= in_port;
      s2_q  <= s1_q;
      qd_q  <= q;
      cap_q <= cap_d;
      rd_q  <= rd_d;
      if (wr_en && (address == ADDR_RISE)) rise_q <= writedata[WIDTH-1:0];
      if (wr_en && (address == ADDR_MASK)) mask_q <= writedata[WIDTH-1:0];
      if (wr_en && (address == ADDR_FALL)) fall_q <= writedata[WIDTH-1:0];
    end
  end

  assign readdata = rd_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_key_edge_pio.sv
// Self-checking bench for key_edge_pio: directed register/timing scenarios
// followed by randomized traffic, all compared against a behavioural model.
module tb_key_edge_pio;

  localparam int WIDTH = 2;
`ifdef KEY_EDGE_PIO_DEBOUNCE_EN
  localparam bit          DBG        = 1'b1;
  localparam logic [31:0] EXP_DB_RST = 32'd50000;
  localparam logic [31:0] EXP_A5     = 32'h1234;
  localparam int          L_EFF      = 4;
`else
  localparam bit          DBG        = 1'b0;
  localparam logic [31:0] EXP_DB_RST = 32'd0;
  localparam logic [31:0] EXP_A5     = 32'd0;
  localparam int          L_EFF      = 1;
`endif

  logic             clk;
  logic             reset_n;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  key_edge_pio #(.WIDTH(WIDTH), .DB_W(16), .DB_RESET(50000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: state as it stands after the most recent clock edge.
  // A channel's debounced level flips once its synchronized input has
  // disagreed with it for L consecutive edges, L = max(db_limit,1).
  logic [WIDTH-1:0] m_s1, m_s2, m_q, m_qd, m_rise, m_fall, m_mask, m_cap;
  logic [15:0]      m_db;
  logic [31:0]      m_rd;
  int               m_start [WIDTH];
  int               cyc = 0;

  function automatic logic [WIDTH-1:0] m_edges();
    return (m_q & ~m_qd & m_rise) | (~m_q & m_qd & m_fall);
  endfunction

  function automatic int m_len();
    if (!DBG) return 1;
    return (m_db == 16'd0) ? 1 : int'(m_db);
  endfunction

  task automatic model_step();
    logic [WIDTH-1:0] nq, ncap, clrm;
    logic [31:0]      nrd;
    bit               wr;
    cyc++;
    if (!reset_n) begin
      m_s1 = '1; m_s2 = '1; m_q = '1; m_qd = '1;
      m_rise = '0; m_fall = '1; m_mask = '0; m_cap = '0;
      m_db = 16'd50000; m_rd = '0;
      for (int c = 0; c < WIDTH; c++) m_start[c] = -1;
      return;
    end
    wr  = chipselect && !write_n;
    nrd = '0;
    case (address)
      3'd0: nrd = 32'(m_q);
      3'd1: nrd = 32'(m_rise);
      3'd2: nrd = 32'(m_mask);
      3'd3: nrd = 32'(m_cap);
      3'd4: nrd = 32'(m_fall);
      3'd5: nrd = DBG ? 32'(m_db) : 32'd0;
      default: nrd = '0;
    endcase
    clrm = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
    ncap = (m_cap & ~clrm) | m_edges();
    nq   = m_q;
    for (int c = 0; c < WIDTH; c++) begin
      if (DBG && wr && address == 3'd5) m_start[c] = -1;
      else if (m_s2[c] == m_q[c]) m_start[c] = -1;
      else begin
        if (m_start[c] < 0) m_start[c] = cyc;
        if (cyc - m_start[c] + 1 >= m_len()) begin
          nq[c] = m_s2[c];
          m_start[c] = -1;
        end
      end
    end
    m_qd = m_q; m_q = nq; m_s2 = m_s1; m_s1 = in_port;
    m_cap = ncap; m_rd = nrd;
    if (wr) begin
      case (address)
        3'd1: m_rise = writedata[WIDTH-1:0];
        3'd2: m_mask = writedata[WIDTH-1:0];
        3'd4: m_fall = writedata[WIDTH-1:0];
        3'd5: if (DBG) m_db = writedata[15:0];
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("readdata", readdata, m_rd);
    check("irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    cycle();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    cycle();
    chipselect = 1'b0;
    d = readdata;
  endtask

  logic [31:0]      rst_exp [8];
  logic [31:0]      rd;
  logic [WIDTH-1:0] e;
  int               n;
  int               r;

  initial begin
    rst_exp = '{32'h3, 32'h0, 32'h0, 32'h0, 32'h3, EXP_DB_RST, 32'h0, 32'h0};
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '1;
    for (int c = 0; c < WIDTH; c++) m_start[c] = -1;
    idle(2);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;

    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      check($sformatf("rst_addr%0d", a), rd, rst_exp[a]);
    end

    // Falling key 0 with db_limit=4: capture visible on readdata L+4 edges later.
    bus_write(3'd5, 32'd4);
    address = 3'd3;
    in_port[0] = 1'b0;
    for (n = 1; n <= 40; n++) begin
      cycle();
      if (readdata != 32'd0) break;
    end
    check("cap_latency", 32'(n), 32'(L_EFF + 4));
    check("irq_masked", {31'b0, irq}, 32'h0);
    bus_write(3'd2, 32'h1);
    check("irq_unmasked", {31'b0, irq}, 32'h1);
    bus_write(3'd3, 32'h3);
    bus_write(3'd2, 32'h0);
    in_port[0] = 1'b1;
    idle(10);

    // Three-cycle glitch on key 1.
    address = 3'd0;
    in_port[1] = 1'b0;
    idle(3);
    in_port[1] = 1'b1;
    idle(10);
`ifdef KEY_EDGE_PIO_DEBOUNCE_EN
    bus_read(3'd0, rd);
    check("glitch_data", rd, 32'h3);
    bus_read(3'd3, rd);
    check("glitch_cap", rd, 32'h0);
`endif
    bus_write(3'd3, 32'h3);

    // Rise-only capture on key 1, then selective write-1-to-clear.
    bus_write(3'd1, 32'h2);
    bus_write(3'd4, 32'h0);
    bus_write(3'd2, 32'h2);
    bus_write(3'd3, 32'h3);
    in_port[1] = 1'b0;
    idle(12);
    bus_read(3'd3, rd);
    check("press_cap", rd, 32'h0);
    in_port[1] = 1'b1;
    idle(12);
    bus_read(3'd3, rd);
    check("release_cap", rd, 32'h2);
    check("release_irq", {31'b0, irq}, 32'h1);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, rd);
    check("w1c_other_bit", rd, 32'h2);
    bus_write(3'd3, 32'h2);
    check("w1c_irq_drop", {31'b0, irq}, 32'h0);
    bus_read(3'd3, rd);
    check("w1c_cleared", rd, 32'h0);

    // Clear of bit 0 lands on the same edge that sets it.
    bus_write(3'd4, 32'h1);
    bus_write(3'd1, 32'h0);
    bus_write(3'd2, 32'h1);
    address = 3'd0;
    in_port[0] = 1'b0;
    r = 0;
    for (int i = 0; i < 40; i++) begin
      e = m_edges();
      if (e[0]) begin r = 1; break; end
      cycle();
    end
    check("w1c_race_found", 32'(r), 32'h1);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, rd);
    check("w1c_race_kept", rd, 32'h1);
    bus_write(3'd3, 32'h3);
    in_port[0] = 1'b1;
    idle(10);

    bus_write(3'd5, 32'h1234);
    bus_read(3'd5, rd);
    check("addr5_rdback", rd, EXP_A5);
    bus_write(3'd5, 32'd3);
    bus_write(3'd0, 32'h0);
    bus_read(3'd0, rd);
    check("data_ro", rd, 32'(m_q));

    // Randomized traffic, including occasional resets mid-debounce.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) in_port = WIDTH'($urandom);
      r = $urandom_range(0, 9);
      address = 3'($urandom_range(0, 7));
      if (r < 2) begin
        chipselect = 1'b1; write_n = 1'b0;
        writedata = (address == 3'd5) ? 32'($urandom_range(0, 6)) : $urandom;
      end else begin
        chipselect = (r == 2);
        write_n = (r == 2) ? 1'b1 : 1'($urandom);
        writedata = $urandom;
      end
      reset_n = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_edge_pio.md
KEY_EDGE_PIO -- requirements
Module: key_edge_pio

Interface
REQ-001 Parameter WIDTH, default 2, number of input channels (legal range 1..32).
REQ-002 Parameter DB_W, default 16, width of the debounce limit register and counters.
REQ-003 Parameter DB_RESET, default 50000, debounce limit loaded at reset.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 address  input  3  register select.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe, valid with chipselect.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  asynchronous key inputs.
REQ-011 readdata  output  32  registered read data.
REQ-012 irq  output  1  interrupt request.

Function
REQ-013 Register map SHALL be: 0 data (debounced, RO), 1 rise_en, 2 irq_mask, 3 edge_capture, 4 fall_en, 5 db_limit; addresses 6-7 read 0, writes ignored.
REQ-014 readdata SHALL be registered every cycle from the current address, 1-cycle latency, bits above the register width zero.
REQ-015 in_port SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-016 Per channel, counter SHALL clear when s2 == q, else increment; when the counter reaches max(db_limit,1)-1 while mismatched, q SHALL take s2 and the counter SHALL clear.
REQ-017 Net latency: in_port change before edge k SHALL update q at edge k+1+max(db_limit,1); pulses on s2 shorter than max(db_limit,1) cycles SHALL never reach q.
REQ-018 db_limit write SHALL take effect next cycle; in-flight counters SHALL be cleared on that write.
REQ-019 Edge detect SHALL use q and its one-cycle-delayed copy qd: rise = q&~qd&rise_en, fall = ~q&qd&fall_en.
REQ-020 edge_capture bit SHALL set on the cycle after its detected edge and stay set until cleared.
REQ-021 Write to address 3 SHALL clear only bits where writedata is 1 (write-1-to-clear).
REQ-022 Simultaneous clear and new edge on the same bit SHALL leave the bit set.
REQ-023 irq SHALL be combinational OR of (edge_capture & irq_mask).
REQ-024 Writes to address 0 SHALL be ignored; rise_en, fall_en, irq_mask take writedata[WIDTH-1:0].

Reset
REQ-025 With reset_n low at a clock edge: readdata=0, s1=s2=q=qd=all ones, counters=0, edge_capture=0, irq_mask=0, rise_en=0, fall_en=all ones, db_limit=DB_RESET; irq therefore 0.
REQ-026 Reset asserted mid-debounce or with pending captures SHALL discard all pending state; no edge SHALL be reported from the reset-value-to-input transition unless the input is low after reset (reported as falling, per REQ-019).

Configuration
REQ-027 Macro KEY_EDGE_PIO_DEBOUNCE_EN defined: debounce per REQ-016..018 present.
REQ-028 Macro undefined: no counters or db_limit register; q SHALL be s2 registered once (latency as db_limit=1); address 5 reads 0, writes ignored.

Structure
REQ-029 Package key_edge_pio_pkg SHALL hold register address constants (ADDR_DATA..ADDR_DBLIM) and default parameter values.
REQ-030 Sub-module key_debounce (one channel: counter, q) SHALL be instantiated WIDTH times via generate.

Verification
REQ-031 Reset, read all addresses -> data=0x3 (WIDTH=2, inputs high), fall_en=0x3, rise_en=0, mask=0, capture=0, db_limit=50000.
REQ-032 db_limit=4, drive in_port[0] low before edge 10 -> q[0] falls at edge 15, edge_capture=0x1 at edge 16; irq high at edge 16 only if mask=0x1.
REQ-033 db_limit=4, 3-cycle low glitch on in_port[1] -> no change in data or edge_capture.
REQ-034 rise_en=0x2, fall_en=0, press/release key 1 -> capture set only on release; write 0x1 to address 3 leaves bit 1 set, write 0x2 clears it and drops irq.
REQ-035 Write-1-to-clear of bit 0 in the same cycle edge_capture[0] would set -> bit 0 remains 1.
REQ-036 Build without KEY_EDGE_PIO_DEBOUNCE_EN, press key 0 before edge k -> capture at edge k+3; address 5 reads 0 after write 0x1234.
